// File: rtl/stats_collector_avlstrm_pkg.sv
// ---------------------------------------------------------------------------
// stats_collector_avlstrm_pkg
// Shared types and constants for the stats channel receive side.
//   stats_t   : one stream beat {addr, val}
//   REG_*     : well-known stat addresses used by the service stats packers
//   sat_inc16 : saturating 16-bit increment for the error counters
// ---------------------------------------------------------------------------
package stats_collector_avlstrm_pkg;

  localparam int STAT_AW = 8;  // stat address width carried in each beat

  typedef struct packed {
    logic [STAT_AW-1:0] addr;
    logic [31:0]        val;
  } stats_t;

  localparam logic [STAT_AW-1:0] REG_PKTS_IN   = 8'd0;
  localparam logic [STAT_AW-1:0] REG_PKTS_OUT  = 8'd1;
  localparam logic [STAT_AW-1:0] REG_BYTES_IN  = 8'd2;
  localparam logic [STAT_AW-1:0] REG_BYTES_OUT = 8'd3;
  localparam logic [STAT_AW-1:0] REG_DROPS     = 8'd4;
  localparam logic [STAT_AW-1:0] REG_ERRORS    = 8'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stats_collector_avlstrm_if.sv
// ---------------------------------------------------------------------------
// avl_stream_if
// Avalon-ST carrying stats_t beats.
//   valid/ready : handshake, beat accepted when both high
//   data        : stats_t beat
//   sop/eop     : first/last beat of a sweep
//   empty       : carried for bus compatibility, unused by the collector
// Modports: tx/master drive the stream, rx/slave consume it.
// ---------------------------------------------------------------------------
interface avl_stream_if;
  import stats_collector_avlstrm_pkg::*;

  logic       valid;
  logic       ready;
  stats_t     data;
  logic       sop;
  logic       eop;
  logic [1:0] empty;

  modport tx     (output valid, data, sop, eop, empty, input ready);
  modport rx     (input valid, data, sop, eop, empty, output ready);
  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/stats_collector_avlstrm_bank.sv
// ---------------------------------------------------------------------------
// stats_bank
// Double-buffered stat image: a working bank written by the stream and a
// committed bank copied from it in one cycle.
//   clk, rst_n  : clock, async active-low reset
//   i_wr_en     : write working[i_wr_idx] <= i_wr_data
//   i_commit    : copy working -> committed (and compute deltas)
//   o_committed : committed image, one word per entry
//   o_delta     : working - committed at commit time
//                 (only when STATS_COLLECTOR_DELTA_EN is defined)
// ---------------------------------------------------------------------------
module stats_bank #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic             i_commit,
`ifdef STATS_COLLECTOR_DELTA_EN
  output logic [31:0]      o_delta     [NUM_REGS],
`endif
  output logic [31:0]      o_committed [NUM_REGS]
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      logic [31:0] r_working;
      logic [31:0] r_committed;

      // The working bank is never cleared between sweeps: entries the packer
      // skips keep their last reported value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_working   <= '0;
          r_committed <= '0;
        end else begin
          if (i_wr_en && (i_wr_idx == IDX_W'(gi)))
            r_working <= i_wr_data;
          if (i_commit)
            r_committed <= r_working;
        end
      end

      assign o_committed[gi] = r_committed;

`ifdef STATS_COLLECTOR_DELTA_EN
      logic [31:0] r_delta;
      // Uses the pre-commit committed value, so this is the change since
      // the previous sweep.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_delta <= '0;
        else if (i_commit)
          r_delta <= r_working - r_committed;
      end
      assign o_delta[gi] = r_delta;
`endif
    end
  endgenerate

endmodule

// File: rtl/stats_collector_avlstrm.sv
// ---------------------------------------------------------------------------
// stats_collector_avlstrm
// Receives one service's stats sweeps over Avalon-ST and exposes a coherent
// committed image through a fixed-latency CSR read port.
//   Clk, Rst_n    : clock, async active-low reset
//   stats_in      : avl_stream_if.rx, stats_t beats with sop/eop
//   csr_address   : read address
//   csr_read      : read strobe
//   csr_readdata  : read data, valid the cycle after the strobe
//   csr_readvalid : one-cycle pulse per read
//   sweep_done    : one-cycle pulse while a sweep commits
// CSR map: 0..N-1 committed, N sweep_cnt, N+1 {abort_cnt, bad_addr_cnt},
//          N+2..2N+1 deltas (STATS_COLLECTOR_DELTA_EN), others read 0.
// Optional feature macro: STATS_COLLECTOR_DELTA_EN.
// ---------------------------------------------------------------------------
module stats_collector_avlstrm
  import stats_collector_avlstrm_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int CSR_AWIDTH = 6
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  avl_stream_if.rx              stats_in,
  input  logic [CSR_AWIDTH-1:0] csr_address,
  input  logic                  csr_read,
  output logic [31:0]           csr_readdata,
  output logic                  csr_readvalid,
  output logic                  sweep_done
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [CSR_AWIDTH-1:0] A_SWEEP = CSR_AWIDTH'(NUM_REGS);
  localparam logic [CSR_AWIDTH-1:0] A_ERR   = CSR_AWIDTH'(NUM_REGS + 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_sweep_cnt;
  logic [15:0] r_abort_cnt;
  logic [15:0] r_bad_addr_cnt;
  logic [31:0] r_csr_rdata;
  logic        r_csr_rvalid;

  logic        w_accept;
  logic        w_in_sweep;   // accepted beat belongs to a sweep (not an orphan)
  logic        w_addr_ok;
  logic        w_wr_en;
  logic        w_abort_inc;
  logic        w_bad_inc;
  logic        w_commit;
  logic [31:0] w_csr_data;
  logic [31:0] w_committed [NUM_REGS];
`ifdef STATS_COLLECTOR_DELTA_EN
  localparam logic [CSR_AWIDTH-1:0] A_DLT0 = CSR_AWIDTH'(NUM_REGS + 2);
  localparam logic [CSR_AWIDTH-1:0] A_DLTN = CSR_AWIDTH'(2 * NUM_REGS + 1);
  logic [31:0] w_delta [NUM_REGS];
`endif

  // Ready is also gated by reset so the source never sees a beat accepted
  // while the collector is held in reset.
  assign stats_in.ready = Rst_n && (r_state != ST_COMMIT);
  assign w_accept       = stats_in.valid && stats_in.ready;
  assign w_in_sweep     = stats_in.sop || (r_state == ST_COLLECT);
  assign w_addr_ok      = (stats_in.data.addr < STAT_AW'(NUM_REGS));
  assign w_wr_en        = w_accept && w_in_sweep && w_addr_ok;
  assign w_bad_inc      = w_accept && w_in_sweep && !w_addr_ok;
  // Orphan in IDLE, or a restart sop arriving mid-sweep.
  assign w_abort_inc    = w_accept && (((r_state == ST_IDLE) && !stats_in.sop) ||
                                       ((r_state == ST_COLLECT) && stats_in.sop));
  assign w_commit       = (r_state == ST_COMMIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && stats_in.sop)
          w_state_next = stats_in.eop ? ST_COMMIT : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_accept && stats_in.eop)
          w_state_next = ST_COMMIT;
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  stats_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (IDX_W'(stats_in.data.addr)),
    .i_wr_data   (stats_in.data.val),
    .i_commit    (w_commit),
`ifdef STATS_COLLECTOR_DELTA_EN
    .o_delta     (w_delta),
`endif
    .o_committed (w_committed)
  );

  always_comb begin
    w_csr_data = '0;
    if (csr_address < A_SWEEP)
      w_csr_data = w_committed[IDX_W'(csr_address)];
    else if (csr_address == A_SWEEP)
      w_csr_data = r_sweep_cnt;
    else if (csr_address == A_ERR)
      w_csr_data = {r_abort_cnt, r_bad_addr_cnt};
`ifdef STATS_COLLECTOR_DELTA_EN
    else if ((csr_address >= A_DLT0) && (csr_address <= A_DLTN))
      w_csr_data = w_delta[IDX_W'(csr_address - A_DLT0)];
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state        <= ST_IDLE;
      r_sweep_cnt    <= '0;
      r_abort_cnt    <= '0;
      r_bad_addr_cnt <= '0;
      r_csr_rdata    <= '0;
      r_csr_rvalid   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_csr_rvalid <= csr_read;
      if (csr_read)
        r_csr_rdata <= w_csr_data;
      if (w_commit)
        r_sweep_cnt <= r_sweep_cnt + 32'd1;
      if (w_abort_inc)
        r_abort_cnt <= sat_inc16(r_abort_cnt);
      if (w_bad_inc)
        r_bad_addr_cnt <= sat_inc16(r_bad_addr_cnt);
    end
  end

  assign csr_readdata  = r_csr_rdata;
  assign csr_readvalid = r_csr_rvalid;
  assign sweep_done    = w_commit;

endmodule

// File: tb/tb_stats_collector_avlstrm.sv
module tb_stats_collector_avlstrm;
  import stats_collector_avlstrm_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [5:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_readdata;
  logic        csr_readvalid;
  logic        sweep_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_sd  = 0;

  avl_stream_if sif();

  stats_collector_avlstrm #(.NUM_REGS(16), .CSR_AWIDTH(6)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .stats_in      (sif),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .csr_readvalid (csr_readvalid),
    .sweep_done    (sweep_done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (sweep_done) n_sd++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else
      $display("ok   %s: 0x%08h", tag, got);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input int a, input int v, input bit s, input bit e);
    int n = 0;
    sif.valid     = 1'b1;
    sif.data.addr = 8'(a);
    sif.data.val  = 32'(v);
    sif.sop       = s;
    sif.eop       = e;
    while (!sif.ready && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 20) check("beat_tmo", 32'(n), 32'd0);
    @(posedge Clk); #1;
    sif.valid = 1'b0;
    sif.sop   = 1'b0;
    sif.eop   = 1'b0;
  endtask

  task automatic sweep(input int n, input int vbase, input bit s, input bit e);
    for (int i = 0; i < n; i++)
      send_beat(i, vbase + i, s && (i == 0), e && (i == n - 1));
  endtask

  task automatic read_chk(input int a, input logic [31:0] exp, input string tag);
    csr_address = 6'(a);
    csr_read    = 1'b1;
    @(posedge Clk); #1;
    csr_read = 1'b0;
    check({tag, "_vld"}, {31'b0, csr_readvalid}, 32'd1);
    check(tag, csr_readdata, exp);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, sif.ready}, 32'd0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    n_sd = 0;
  endtask

  initial begin
    sif.valid = 1'b0;
    sif.data  = '0;
    sif.sop   = 1'b0;
    sif.eop   = 1'b0;
    sif.empty = 2'd0;

    // Reset state
    do_reset();
    check("rst_rdata", csr_readdata, 32'd0);
    check("rst_rvalid", {31'b0, csr_readvalid}, 32'd0);
    check("rst_sdone", {31'b0, sweep_done}, 32'd0);
    check("idle_ready", {31'b0, sif.ready}, 32'd1);

    // Full 16-beat sweep; read addr 3 in the COMMIT cycle, then after
    sweep(16, 100, 1'b1, 1'b1);
    check("commit_ready", {31'b0, sif.ready}, 32'd0);
    check("commit_sdone", {31'b0, sweep_done}, 32'd1);
    read_chk(3, 32'd0, "rd3_old");
    read_chk(3, 32'd103, "rd3_new");
    for (int i = 0; i < 16; i++)
      read_chk(i, 32'(100 + i), $sformatf("s1_rd%0d", i));
    read_chk(16, 32'd1, "s1_sweep");
    read_chk(17, 32'd0, "s1_err");
`ifdef STATS_COLLECTOR_DELTA_EN
    read_chk(18, 32'd100, "s1_delta0");
`else
    read_chk(18, 32'd0, "s1_delta0");
`endif
    read_chk(40, 32'd0, "s1_unmapped");
    check("s1_sdone_cnt", 32'(n_sd), 32'd1);

    // Restart mid-sweep
    do_reset();
    sweep(5, 200, 1'b1, 1'b0);
    sweep(16, 300, 1'b1, 1'b1);
    @(posedge Clk); #1;
    read_chk(17, 32'h0001_0000, "rs_err");
    read_chk(16, 32'd1, "rs_sweep");
    read_chk(2, 32'd302, "rs_rd2");
    read_chk(4, 32'd304, "rs_rd4");

    // Out-of-range address in a single sop+eop sweep
    do_reset();
    send_beat(20, 999, 1'b1, 1'b1);
    @(posedge Clk); #1;
    read_chk(17, 32'h0000_0001, "bad_err");
    read_chk(16, 32'd1, "bad_sweep");
    read_chk(4, 32'd0, "bad_rd4");

    // Orphan beat in IDLE, then a one-beat sweep not touching addr 5
    do_reset();
    send_beat(5, 55, 1'b0, 1'b0);
    @(posedge Clk); #1;
    read_chk(17, 32'h0001_0000, "orph_err");
    read_chk(16, 32'd0, "orph_sweep");
    send_beat(0, 1, 1'b1, 1'b1);
    @(posedge Clk); #1;
    read_chk(5, 32'd0, "orph_rd5");
    read_chk(0, 32'd1, "orph_rd0");

    // Two sweeps for delta; addr 7 only written in the first
    do_reset();
    send_beat(2, 50, 1'b1, 1'b0);
    send_beat(7, 70, 1'b0, 1'b1);
    @(posedge Clk); #1;
    send_beat(2, 80, 1'b1, 1'b1);
    @(posedge Clk); #1;
    read_chk(2, 32'd80, "dl_rd2");
    read_chk(7, 32'd70, "dl_rd7_kept");
    read_chk(16, 32'd2, "dl_sweep");
`ifdef STATS_COLLECTOR_DELTA_EN
    read_chk(20, 32'd30, "dl_delta2");
`else
    read_chk(20, 32'd0, "dl_delta2");
`endif
    check("dl_sdone_cnt", 32'(n_sd), 32'd2);

    // Reset pulsed mid-sweep
    do_reset();
    sweep(7, 500, 1'b1, 1'b0);
    Rst_n = 1'b0;
    #1;
    check("mid_ready0", {31'b0, sif.ready}, 32'd0);
    @(posedge Clk); #1;
    check("mid_ready1", {31'b0, sif.ready}, 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    read_chk(0, 32'd0, "mid_rd0");
    read_chk(6, 32'd0, "mid_rd6");
    read_chk(16, 32'd0, "mid_sweep");
    read_chk(17, 32'd0, "mid_err");
    n_sd = 0;
    sweep(16, 600, 1'b1, 1'b1);
    @(posedge Clk); #1;
    read_chk(6, 32'd606, "mid2_rd6");
    read_chk(15, 32'd615, "mid2_rd15");
    read_chk(16, 32'd1, "mid2_sweep");
    read_chk(17, 32'd0, "mid2_err");
    check("mid2_sdone_cnt", 32'(n_sd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
